pipe_stage_regs: RTL and testbench
==================================

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 SHALL have clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have stall/bubble controls F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, input, 1 each, from the hazard-control unit.
REQ-004 SHALL have f_predPC, input, 64, next predicted PC, and F_predPC, output, 64, registered predicted PC.
REQ-005 SHALL have fetch bundle f_stat/f_icode/f_ifun/f_rA/f_rB/f_valC/f_valP, input, 3/4/4/4/4/64/64, registered onto outputs D_stat…D_valP of the same widths.
REQ-006 SHALL have decode bundle d_stat/d_icode/d_ifun/d_valC/d_valA/d_valB/d_dstE/d_dstM/d_srcA/d_srcB, input, 3/4/4/64/64/64/4/4/4/4, registered onto outputs E_stat…E_srcB.
REQ-007 SHALL have execute bundle e_stat/e_icode/e_Cnd/e_valE/e_valA/e_dstE/e_dstM, input, 3/4/1/64/64/4/4, registered onto outputs M_stat…M_dstM.
REQ-008 SHALL have memory bundle m_stat/m_icode/m_valE/m_valM/m_dstE/m_dstM, input, 3/4/64/64/4/4, registered onto outputs W_stat…W_dstM.
REQ-009 SHALL have ctrl_err, output, 1, sticky flag set on illegal control combinations.
REQ-010 SHALL have halted, output, 1, high when W_stat is SHLT, SADR or SINS.
REQ-011 SHALL have bubble_cnt, output, 16, saturating count of cycles in which any bubble was inserted.

Function
REQ-012 Per stage register X, each clk rising edge SHALL: hold if X_stall; else load bubble if X_bubble; else load the stage inputs.
REQ-013 Bubble contents SHALL be: stat=SAOK (3'h1), icode=INOP (4'h1), ifun=0, all register IDs=RNONE (4'hF), all 64-bit data=0, Cnd=0.
REQ-014 F register SHALL honour F_stall only (no bubble); D honours D_stall/D_bubble; E honours E_bubble only; M honours M_bubble only; W honours W_stall only.
REQ-015 Simultaneous D_stall and D_bubble SHALL be resolved as stall (hold) and SHALL set ctrl_err from the next edge until reset.
REQ-016 Outputs SHALL be driven directly from flops; data latency through each stage is exactly one cycle.
REQ-017 A stage SHALL advance independently; a stalled upstream stage SHALL not block a downstream stage from loading (bubbles are inserted by control, not by this block).
REQ-018 halted SHALL be combinational from W_stat; while W_stall is high W holds, so halted stays asserted until reset.
REQ-019 bubble_cnt SHALL increment by 1 on each edge where D_bubble, E_bubble or M_bubble caused a bubble load, and SHALL saturate at 16'hFFFF without wrap.
REQ-020 Status encodings SHALL be SAOK=1, SHLT=2, SADR=3, SINS=4; other values pass through unmodified.

Reset
REQ-021 rst high SHALL immediately, without clk, force F_predPC=0, D/E/M/W registers to bubble contents, ctrl_err=0, bubble_cnt=0.
REQ-022 rst asserted mid-operation SHALL discard all in-flight instructions; first edge after deassertion loads normally.
REQ-023 Stall/bubble inputs SHALL be ignored while rst is high.

Structure
REQ-024 Icode constants (INOP, IJXX, IMRMOVQ, IRET, IPOPQ, IOPQ), status codes, RNONE and bubble values SHALL live in a shared y86_pkg used also by hazard control and stages.
REQ-025 One sub-module, pipe_reg, SHALL implement a parameterised-width register with stall/bubble/bubble-value inputs, instantiated once per stage.

Verification
REQ-026 Reset, then f_icode=4'h3, f_valC=64'h10 with no controls -> D_icode=3, D_valC=0x10 after one edge; E_icode=3 after the next.
REQ-027 D_stall=1, F_stall=1, E_bubble=1 for one cycle -> D and F_predPC unchanged, E_icode=1, E_dstE=4'hF, bubble_cnt=1.
REQ-028 D_stall=1 and D_bubble=1 together -> D holds previous value, ctrl_err=1 and stays 1 after controls drop.
REQ-029 m_stat=3'h2 loaded into W, then W_stall=1 -> halted=1, W_stat stays 2 over 5 edges despite changing m_* inputs.
REQ-030 Force 65536 bubble cycles -> bubble_cnt=16'hFFFF and stays there; async rst pulse between edges -> all outputs reset before next edge.

Source files
------------

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Definitions shared by the Y86-64 pipeline blocks: hazard control, the
// stage logic and the pipeline register bank.
//   - status codes and icode constants
//   - the RNONE register ID
//   - packed layouts of the D/E/M/W pipeline registers
//   - bubble contents for each pipeline register
//   - small helper functions
// ---------------------------------------------------------------------------
package y86_pkg;

  // Status codes. Any other value is carried through the pipeline unchanged.
  localparam logic [2:0] SAOK = 3'h1;
  localparam logic [2:0] SHLT = 3'h2;
  localparam logic [2:0] SADR = 3'h3;
  localparam logic [2:0] SINS = 3'h4;

  // Instruction codes.
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register ID meaning "no register".
  localparam logic [3:0] RNONE = 4'hF;

  // Action a pipeline register takes on a clock edge.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } reg_act_e;

  // Layout of the D register (written by fetch).
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] val_c;
    logic [63:0] val_p;
  } d_reg_t;

  // Layout of the E register (written by decode).
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
  } e_reg_t;

  // Layout of the M register (written by execute).
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;

  // Layout of the W register (written by memory).
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  // Bubble contents: a status-OK nop that writes no register.
  localparam d_reg_t D_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                  ra: RNONE, rb: RNONE,
                                  val_c: 64'h0, val_p: 64'h0};

  localparam e_reg_t E_BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0,
                                  val_c: 64'h0, val_a: 64'h0, val_b: 64'h0,
                                  dst_e: RNONE, dst_m: RNONE,
                                  src_a: RNONE, src_b: RNONE};

  localparam m_reg_t M_BUBBLE = '{stat: SAOK, icode: INOP, cnd: 1'b0,
                                  val_e: 64'h0, val_a: 64'h0,
                                  dst_e: RNONE, dst_m: RNONE};

  localparam w_reg_t W_BUBBLE = '{stat: SAOK, icode: INOP,
                                  val_e: 64'h0, val_m: 64'h0,
                                  dst_e: RNONE, dst_m: RNONE};

  // True for the status codes that stop the machine.
  function automatic logic stat_is_halt(input logic [2:0] stat);
    logic res;
    case (stat)
      SHLT:    res = 1'b1;
      SADR:    res = 1'b1;
      SINS:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    logic [15:0] res;
    if (cnt == 16'hFFFF) begin
      res = cnt;
    end else begin
      res = cnt + 16'h0001;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
// One pipeline register of parameterised width with hold and bubble control.
// On each rising clock edge, in priority order:
//   - stall  : keep the current contents
//   - bubble : load bubble_val
//   - neither: load d
// rst clears the register asynchronously to RST_VAL.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   stall, bubble     per-edge control
//   bubble_val [W]    contents loaded on a bubble
//   d [W]             next stage contents
//   q [W]             registered contents, driven straight from the flops
// ---------------------------------------------------------------------------
module pipe_reg
  import y86_pkg::*;
#(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] bubble_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  reg_act_e     act_s;
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Pick the action for this edge (stall wins over bubble) and the next value.
  always_comb begin
    act_s  = ACT_LOAD;
    data_d = data_q;
    if (stall) begin
      act_s = ACT_HOLD;
    end else if (bubble) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
    case (act_s)
      ACT_HOLD:   data_d = data_q;
      ACT_BUBBLE: data_d = bubble_val;
      ACT_LOAD:   data_d = d;
      default:    data_d = data_q;
    endcase
  end

  // Register storage with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// ---------------------------------------------------------------------------
// pipe_stage_regs
// The F, D, E, M and W pipeline registers of a Y86-64 pipeline, plus:
//   - a sticky control-error flag
//   - a halted indication
//   - a saturating counter of bubble cycles
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   F_stall, D_stall, D_bubble,   hazard-control inputs
//   E_bubble, M_bubble, W_stall
//   f_predPC  -> F_predPC         predicted PC
//   f_*       -> D_*              fetch bundle
//   d_*       -> E_*              decode bundle
//   e_*       -> M_*              execute bundle
//   m_*       -> W_*              memory bundle
//   ctrl_err                      set once D_stall and D_bubble are seen
//                                 together; cleared only by reset
//   halted                        W_stat is SHLT, SADR or SINS
//   bubble_cnt                    edges on which any bubble was loaded,
//                                 saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module pipe_stage_regs
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic        E_bubble,
  input  logic        M_bubble,
  input  logic        W_stall,
  input  logic [63:0] f_predPC,
  output logic [63:0] F_predPC,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  input  logic [2:0]  d_stat,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [63:0] d_valC,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [2:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  input  logic [2:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic        e_Cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  output logic [2:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  input  logic [2:0]  m_stat,
  input  logic [3:0]  m_icode,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic        ctrl_err,
  output logic        halted,
  output logic [15:0] bubble_cnt
);

  d_reg_t d_in_s, d_q;
  e_reg_t e_in_s, e_q;
  m_reg_t m_in_s, m_q;
  w_reg_t w_in_s, w_q;

  logic        ctrl_err_d, ctrl_err_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic        bubble_evt_s;

  assign d_in_s = '{stat: f_stat, icode: f_icode, ifun: f_ifun,
                    ra: f_rA, rb: f_rB, val_c: f_valC, val_p: f_valP};

  assign e_in_s = '{stat: d_stat, icode: d_icode, ifun: d_ifun,
                    val_c: d_valC, val_a: d_valA, val_b: d_valB,
                    dst_e: d_dstE, dst_m: d_dstM,
                    src_a: d_srcA, src_b: d_srcB};

  assign m_in_s = '{stat: e_stat, icode: e_icode, cnd: e_Cnd,
                    val_e: e_valE, val_a: e_valA,
                    dst_e: e_dstE, dst_m: e_dstM};

  assign w_in_s = '{stat: m_stat, icode: m_icode,
                    val_e: m_valE, val_m: m_valM,
                    dst_e: m_dstE, dst_m: m_dstM};

  // F has no bubble input; it resets to PC 0.
  pipe_reg #(.W(64), .RST_VAL(64'h0)) u_f_reg (
    .clk(clk), .rst(rst), .stall(F_stall), .bubble(1'b0),
    .bubble_val(64'h0), .d(f_predPC), .q(F_predPC)
  );

  pipe_reg #(.W($bits(d_reg_t)), .RST_VAL(D_BUBBLE)) u_d_reg (
    .clk(clk), .rst(rst), .stall(D_stall), .bubble(D_bubble),
    .bubble_val(D_BUBBLE), .d(d_in_s), .q(d_q)
  );

  pipe_reg #(.W($bits(e_reg_t)), .RST_VAL(E_BUBBLE)) u_e_reg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(E_bubble),
    .bubble_val(E_BUBBLE), .d(e_in_s), .q(e_q)
  );

  pipe_reg #(.W($bits(m_reg_t)), .RST_VAL(M_BUBBLE)) u_m_reg (
    .clk(clk), .rst(rst), .stall(1'b0), .bubble(M_bubble),
    .bubble_val(M_BUBBLE), .d(m_in_s), .q(m_q)
  );

  // W has no bubble input.
  pipe_reg #(.W($bits(w_reg_t)), .RST_VAL(W_BUBBLE)) u_w_reg (
    .clk(clk), .rst(rst), .stall(W_stall), .bubble(1'b0),
    .bubble_val(W_BUBBLE), .d(w_in_s), .q(w_q)
  );

  // Next values for the error flag and the bubble counter.
  always_comb begin
    ctrl_err_d   = ctrl_err_q;
    bubble_cnt_d = bubble_cnt_q;
    // With both D controls high, D holds, so no D bubble is loaded and
    // that case does not count as a bubble cycle.
    bubble_evt_s = (D_bubble & ~D_stall) | E_bubble | M_bubble;
    if (D_stall & D_bubble) begin
      ctrl_err_d = 1'b1;
    end else begin
      ctrl_err_d = ctrl_err_q;
    end
    if (bubble_evt_s) begin
      bubble_cnt_d = sat_inc16(bubble_cnt_q);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Status flops with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_err_q   <= 1'b0;
      bubble_cnt_q <= 16'h0000;
    end else begin
      ctrl_err_q   <= ctrl_err_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ctrl_err   = ctrl_err_q;
  assign bubble_cnt = bubble_cnt_q;
  assign halted     = stat_is_halt(w_q.stat);

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.val_c;
  assign D_valP  = d_q.val_p;

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_Cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [63:0] f_predPC, F_predPC;
  logic [2:0]  f_stat;  logic [3:0] f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [2:0]  D_stat;  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [2:0]  d_stat;  logic [3:0] d_icode, d_ifun;
  logic [63:0] d_valC, d_valA, d_valB;
  logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
  logic [2:0]  E_stat;  logic [3:0] E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
  logic [2:0]  e_stat;  logic [3:0] e_icode; logic e_Cnd;
  logic [63:0] e_valE, e_valA; logic [3:0] e_dstE, e_dstM;
  logic [2:0]  M_stat;  logic [3:0] M_icode; logic M_Cnd;
  logic [63:0] M_valE, M_valA; logic [3:0] M_dstE, M_dstM;
  logic [2:0]  m_stat;  logic [3:0] m_icode;
  logic [63:0] m_valE, m_valM; logic [3:0] m_dstE, m_dstM;
  logic [2:0]  W_stat;  logic [3:0] W_icode;
  logic [63:0] W_valE, W_valM; logic [3:0] W_dstE, W_dstM;
  logic        ctrl_err, halted;
  logic [15:0] bubble_cnt;

  pipe_stage_regs dut (
    .clk(clk), .rst(rst),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .f_predPC(f_predPC), .F_predPC(F_predPC),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE),
    .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .ctrl_err(ctrl_err), .halted(halted), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Bubble images written straight from the stated contents:
  // stat=1, icode=1, ifun=0, register IDs=F, data=0, Cnd=0.
  localparam logic [146:0] BUB_D = {3'h1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0};
  localparam logic [218:0] BUB_E = {3'h1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0,
                                    4'hF, 4'hF, 4'hF, 4'hF};
  localparam logic [143:0] BUB_M = {3'h1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};
  localparam logic [142:0] BUB_W = {3'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF};

  // Reference model state.
  logic [63:0]  mdl_f;
  logic [146:0] mdl_d;
  logic [218:0] mdl_e;
  logic [143:0] mdl_m;
  logic [142:0] mdl_w;
  logic         mdl_err;
  int           mdl_bubbles;   // unbounded count; the output is its saturation

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [146:0] d_in_v();
    return {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
  endfunction
  function automatic logic [218:0] e_in_v();
    return {d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB};
  endfunction
  function automatic logic [143:0] m_in_v();
    return {e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM};
  endfunction
  function automatic logic [142:0] w_in_v();
    return {m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM};
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_f = 64'h0; mdl_d = BUB_D; mdl_e = BUB_E; mdl_m = BUB_M; mdl_w = BUB_W;
    mdl_err = 1'b0; mdl_bubbles = 0;
  endtask

  task automatic check_all(input string where);
    logic [2:0]  ws;
    logic [15:0] cnt_exp;
    ws = mdl_w[142:140];
    cnt_exp = (mdl_bubbles > 65535) ? 16'hFFFF : 16'(mdl_bubbles);
    chk({where, ".F"}, {192'h0, F_predPC}, {192'h0, mdl_f});
    chk({where, ".D"}, {109'h0, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP},
        {109'h0, mdl_d});
    chk({where, ".E"}, {37'h0, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
                        E_dstE, E_dstM, E_srcA, E_srcB}, {37'h0, mdl_e});
    chk({where, ".M"}, {112'h0, M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM},
        {112'h0, mdl_m});
    chk({where, ".W"}, {113'h0, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM},
        {113'h0, mdl_w});
    chk({where, ".ctrl_err"}, {255'h0, ctrl_err}, {255'h0, mdl_err});
    chk({where, ".halted"}, {255'h0, halted},
        {255'h0, (ws == 3'd2 || ws == 3'd3 || ws == 3'd4)});
    chk({where, ".bubble_cnt"}, {240'h0, bubble_cnt}, {240'h0, cnt_exp});
  endtask

  task automatic rnd_data();
    f_predPC = r64();
    f_stat = 3'($urandom()); f_icode = 4'($urandom()); f_ifun = 4'($urandom());
    f_rA = 4'($urandom()); f_rB = 4'($urandom()); f_valC = r64(); f_valP = r64();
    d_stat = 3'($urandom()); d_icode = 4'($urandom()); d_ifun = 4'($urandom());
    d_valC = r64(); d_valA = r64(); d_valB = r64();
    d_dstE = 4'($urandom()); d_dstM = 4'($urandom());
    d_srcA = 4'($urandom()); d_srcB = 4'($urandom());
    e_stat = 3'($urandom()); e_icode = 4'($urandom()); e_Cnd = 1'($urandom());
    e_valE = r64(); e_valA = r64(); e_dstE = 4'($urandom()); e_dstM = 4'($urandom());
    m_stat = 3'($urandom()); m_icode = 4'($urandom()); m_valE = r64(); m_valM = r64();
    m_dstE = 4'($urandom()); m_dstM = 4'($urandom());
  endtask

  task automatic ctl(input logic fs, ds, db, eb, mb, ws);
    F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb; M_bubble = mb; W_stall = ws;
  endtask

  // One clock edge; the model is advanced from the inputs the DUT samples.
  task automatic tick();
    logic [63:0]  nf;
    logic [146:0] nd;
    logic [218:0] ne;
    logic [143:0] nm;
    logic [142:0] nw;
    logic         nerr;
    int           nb;
    if (rst) begin
      nf = 64'h0; nd = BUB_D; ne = BUB_E; nm = BUB_M; nw = BUB_W; nerr = 1'b0; nb = 0;
    end else begin
      nf = F_stall ? mdl_f : f_predPC;
      nd = D_stall ? mdl_d : (D_bubble ? BUB_D : d_in_v());
      ne = E_bubble ? BUB_E : e_in_v();
      nm = M_bubble ? BUB_M : m_in_v();
      nw = W_stall ? mdl_w : w_in_v();
      nerr = mdl_err | (D_stall & D_bubble);
      nb = mdl_bubbles + (((D_bubble && !D_stall) || E_bubble || M_bubble) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    mdl_f = nf; mdl_d = nd; mdl_e = ne; mdl_m = nm; mdl_w = nw;
    mdl_err = nerr; mdl_bubbles = nb;
  endtask

  initial begin
    logic [146:0] d_before;
    logic [63:0]  f_before;

    // Reset is asynchronous: outputs are valid before any clock edge.
    rst = 1'b1;
    ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    rnd_data();
    mdl_reset();
    #2;
    check_all("reset_async");
    // Controls are ignored while reset is held across an edge.
    tick();
    check_all("reset_edge");
    rst = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic one-cycle latency through D and then E.
    rnd_data();
    f_icode = 4'h3; f_valC = 64'h10;
    tick();
    chk("lat.D_icode", {252'h0, D_icode}, {252'h0, 4'h3});
    chk("lat.D_valC", {192'h0, D_valC}, {192'h0, 64'h10});
    check_all("lat1");
    rnd_data();
    d_icode = 4'h3;
    tick();
    chk("lat.E_icode", {252'h0, E_icode}, {252'h0, 4'h3});
    check_all("lat2");

    // F and D stalled while E takes a bubble.
    rnd_data();
    d_before = mdl_d;
    f_before = mdl_f;
    ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("stall.D_hold", {109'h0, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP},
        {109'h0, d_before});
    chk("stall.F_hold", {192'h0, F_predPC}, {192'h0, f_before});
    chk("stall.E_icode", {252'h0, E_icode}, {252'h0, 4'h1});
    chk("stall.E_dstE", {252'h0, E_dstE}, {252'h0, 4'hF});
    chk("stall.bubble_cnt", {240'h0, bubble_cnt}, {240'h0, 16'h0001});
    check_all("stall");

    // D_stall with D_bubble: hold, and raise a sticky error.
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rnd_data();
    tick();
    rnd_data();
    d_before = mdl_d;
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("conflict.D_hold", {109'h0, D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP},
        {109'h0, d_before});
    chk("conflict.ctrl_err", {255'h0, ctrl_err}, {255'h0, 1'b1});
    check_all("conflict");
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rnd_data();
    tick();
    tick();
    chk("conflict.sticky", {255'h0, ctrl_err}, {255'h0, 1'b1});
    check_all("conflict_after");

    // Halt status captured in W and held by W_stall.
    rnd_data();
    m_stat = 3'h2;
    tick();
    chk("halt.halted", {255'h0, halted}, {255'h0, 1'b1});
    W_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnd_data();
      tick();
      chk("halt.W_stat", {253'h0, W_stat}, {253'h0, 3'h2});
      chk("halt.hold", {255'h0, halted}, {255'h0, 1'b1});
      check_all("halt");
    end
    W_stall = 1'b0;

    // Randomised traffic with sparse controls.
    for (int i = 0; i < 300; i++) begin
      rnd_data();
      ctl($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
          $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0);
      tick();
      check_all("random");
    end

    // Drive the bubble counter into saturation.
    ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      tick();
    end
    chk("sat.bubble_cnt", {240'h0, bubble_cnt}, {240'h0, 16'hFFFF});
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk("sat.hold", {240'h0, bubble_cnt}, {240'h0, 16'hFFFF});
    check_all("sat");

    // Reset pulse between edges clears everything without a clock.
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rnd_data();
    tick();
    #2;
    rst = 1'b1;
    mdl_reset();
    #1;
    check_all("midreset");
    rst = 1'b0;
    // First edge after release loads normally.
    rnd_data();
    tick();
    check_all("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
